// File: rtl/addr_seq.sv
// addr_seq: 6502 address sequencer (pc/ar/ir, reset-vector fetch, addr/rw drive); in ps/mm/mw/il/ar_*_ld/din, out addr/rw/pc/ar/ir/page_cross/ready
module addr_seq #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter bit          USE_VECTOR   = 1'b1,
  parameter logic [15:0] PC_INIT      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ps,
  input  logic        mm,
  input  logic        mw,
  input  logic        il,
  input  logic        ar_lo_ld,
  input  logic        ar_hi_ld,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic        rw,
  output logic [15:0] pc,
  output logic [15:0] ar,
  output logic [7:0]  ir,
  output logic        page_cross,
  output logic        ready
);
  localparam logic [1:0] HOLD = 2'd0, INC = 2'd1, REL = 2'd2, ABS = 2'd3;
  typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN} state_t;
  state_t      state;
  logic [7:0]  vec_lo;
  logic [15:0] pc_rel;
  assign pc_rel = pc + {{8{din[7]}}, din};
  always_comb begin
    addr = state == VEC_LO ? RESET_VECTOR : state == VEC_HI ? RESET_VECTOR + 16'd1 : mm ? ar : pc;
    rw   = state == RUN ? mw : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= USE_VECTOR ? VEC_LO : RUN;
      ready      <= !USE_VECTOR;
      pc         <= PC_INIT;
      ar         <= 16'h0000;
      ir         <= 8'h00;
      page_cross <= 1'b0;
      vec_lo     <= 8'h00;
    end else if (state == VEC_LO) begin
      vec_lo <= din;
      state  <= VEC_HI;
    end else if (state == VEC_HI) begin
      pc    <= {din, vec_lo};
      state <= RUN;
      ready <= 1'b1;
    end else begin
      pc         <= ps == INC ? pc + 16'd1 : ps == REL ? pc_rel : ps == ABS ? {din, ar[7:0]} : pc;
      page_cross <= ps == REL ? pc_rel[15:8] != pc[15:8] : ps == HOLD ? page_cross : 1'b0;
      ar[7:0]    <= ar_lo_ld ? din : ar[7:0];
      ar[15:8]   <= ar_hi_ld ? din : ar[15:8];
      ir         <= il ? din : ir;
    end
  end
endmodule

// File: tb/tb_addr_seq.sv
// tb_addr_seq: scripted and randomized checks of addr_seq against a behavioural model
module tb_addr_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  ps = 2'd0;
  logic        mm = 1'b0, mw = 1'b1, il = 1'b0, ar_lo_ld = 1'b0, ar_hi_ld = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [15:0] addr, pc, ar;
  logic        rw, page_cross, ready;
  logic [7:0]  ir;
  int          n_checks = 0, n_fail = 0;
  logic [15:0] m_pc, m_ar;
  logic [7:0]  m_ir;
  logic        m_pcx;

  addr_seq dut (
    .clk(clk), .rst_n(rst_n), .ps(ps), .mm(mm), .mw(mw), .il(il),
    .ar_lo_ld(ar_lo_ld), .ar_hi_ld(ar_hi_ld), .din(din),
    .addr(addr), .rw(rw), .pc(pc), .ar(ar), .ir(ir),
    .page_cross(page_cross), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] p, input logic m, input logic w, input logic l,
                       input logic lo, input logic hi, input logic [7:0] d);
    ps = p; mm = m; mw = w; il = l; ar_lo_ld = lo; ar_hi_ld = hi; din = d;
  endtask

  task automatic model_step();
    int off, np;
    off = din < 8'd128 ? int'(din) : int'(din) - 256;
    np  = int'(m_pc);
    if (ps == 2'd1) np = (np + 1) % 65536;
    else if (ps == 2'd2) np = (np + off + 65536) % 65536;
    else if (ps == 2'd3) np = int'(din) * 256 + int'(m_ar) % 256;
    if (ps == 2'd2) m_pcx = (np / 256) != (int'(m_pc) / 256);
    else if (ps != 2'd0) m_pcx = 1'b0;
    m_pc = np[15:0];
    if (ar_lo_ld) m_ar[7:0] = din;
    if (ar_hi_ld) m_ar[15:8] = din;
    if (il) m_ir = din;
  endtask

  task automatic tick(input bit upd);
    @(posedge clk);
    if (upd) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    n_checks++; if (ar !== 16'h0000) begin n_fail++; $display("FAIL reset_ar: got %h expected 0000", ar); end
    n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL reset_ir: got %h expected 00", ir); end
    n_checks++; if (page_cross !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got pcx=%b rdy=%b expected 0 0", page_cross, ready); end
    n_checks++; if (addr !== 16'hFFFC || rw !== 1'b1) begin n_fail++; $display("FAIL reset_addr: got %h rw=%b expected FFFC rw=1", addr, rw); end
  endtask

  task automatic test_vector();
    drive(2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h34);
    rst_n = 1'b1;
    #1;
    n_checks++; if (addr !== 16'hFFFC || rw !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL vec_lo: got %h rw=%b rdy=%b expected FFFC 1 0", addr, rw, ready); end
    tick(1'b0);
    din = 8'h12;
    #1;
    n_checks++; if (addr !== 16'hFFFD || rw !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL vec_hi: got %h rw=%b rdy=%b expected FFFD 1 0", addr, rw, ready); end
    n_checks++; if (ar !== 16'h0000 || ir !== 8'h00 || pc !== 16'h0000) begin n_fail++; $display("FAIL vec_ignore: got ar=%h ir=%h pc=%h expected 0000 00 0000", ar, ir, pc); end
    tick(1'b0);
    n_checks++; if (pc !== 16'h1234 || ready !== 1'b1) begin n_fail++; $display("FAIL vec_done: got pc=%h rdy=%b expected 1234 1", pc, ready); end
    n_checks++; if (ar !== 16'h0000 || ir !== 8'h00 || page_cross !== 1'b0) begin n_fail++; $display("FAIL vec_hold: got ar=%h ir=%h pcx=%b expected 0000 00 0", ar, ir, page_cross); end
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    n_checks++; if (addr !== 16'h1234 || rw !== 1'b1) begin n_fail++; $display("FAIL run_addr: got %h rw=%b expected 1234 1", addr, rw); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== 16'h0000 || ready !== 1'b0) begin n_fail++; $display("FAIL run_reset: got pc=%h rdy=%b expected 0000 0", pc, ready); end
    @(negedge clk);
    rst_n = 1'b1;
    din = 8'hF0;
    tick(1'b0);
    din = 8'h10;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== 16'h0000 || ready !== 1'b0 || addr !== 16'hFFFC) begin n_fail++; $display("FAIL hi_reset: got pc=%h rdy=%b addr=%h expected 0000 0 FFFC", pc, ready, addr); end
    @(negedge clk);
    rst_n = 1'b1;
    din = 8'hF0;
    #1;
    n_checks++; if (addr !== 16'hFFFC || rw !== 1'b1) begin n_fail++; $display("FAIL refetch: got %h rw=%b expected FFFC 1", addr, rw); end
    tick(1'b0);
    din = 8'h10;
    tick(1'b0);
    n_checks++; if (pc !== 16'h10F0 || ready !== 1'b1) begin n_fail++; $display("FAIL refetch_pc: got %h rdy=%b expected 10F0 1", pc, ready); end
    m_pc = 16'h10F0; m_ar = 16'h0000; m_ir = 8'h00; m_pcx = 1'b0;
  endtask

  task automatic test_rel();
    drive(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20); tick(1'b1);
    n_checks++; if (pc !== 16'h1110 || page_cross !== 1'b1) begin n_fail++; $display("FAIL rel_fwd: got %h pcx=%b expected 1110 1", pc, page_cross); end
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h34); tick(1'b1);
    drive(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12); tick(1'b1);
    n_checks++; if (pc !== 16'h1234 || page_cross !== 1'b0) begin n_fail++; $display("FAIL abs_1234: got %h pcx=%b expected 1234 0", pc, page_cross); end
    drive(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0); tick(1'b1);
    n_checks++; if (pc !== 16'h1224 || page_cross !== 1'b0) begin n_fail++; $display("FAIL rel_back: got %h pcx=%b expected 1224 0", pc, page_cross); end
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10); tick(1'b1);
    drive(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick(1'b1);
    drive(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80); tick(1'b1);
    n_checks++; if (pc !== 16'hFF90 || page_cross !== 1'b1) begin n_fail++; $display("FAIL rel_wrap: got %h pcx=%b expected FF90 1", pc, page_cross); end
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick(1'b1);
    n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL pcx_hold: got %b expected 1", page_cross); end
  endtask

  task automatic test_wrap();
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF); tick(1'b1);
    drive(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF); tick(1'b1);
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick(1'b1);
    n_checks++; if (pc !== 16'h0000 || page_cross !== 1'b0) begin n_fail++; $display("FAIL inc_wrap: got %h pcx=%b expected 0000 0", pc, page_cross); end
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h34); tick(1'b1);
    drive(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12); tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom)); tick(1'b1);
      n_checks++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL hold_%0d: got %h expected 1234", i, pc); end
    end
  endtask

  task automatic test_abs_ir();
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick(1'b1);
    drive(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC0); tick(1'b1);
    n_checks++; if (pc !== 16'hC000 || ar[7:0] !== 8'hC0) begin n_fail++; $display("FAIL abs_old_lo: got pc=%h arlo=%h expected C000 C0", pc, ar[7:0]); end
    drive(2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA9); tick(1'b1);
    n_checks++; if (ir !== 8'hA9 || pc !== 16'hC001) begin n_fail++; $display("FAIL ir_load: got ir=%h pc=%h expected A9 C001", ir, pc); end
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick(1'b1);
    n_checks++; if (ir !== 8'hA9) begin n_fail++; $display("FAIL ir_hold: got %h expected A9", ir); end
  endtask

  task automatic test_mux();
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02); tick(1'b1);
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick(1'b1);
    drive(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    n_checks++; if (addr !== 16'h0200 || rw !== 1'b0) begin n_fail++; $display("FAIL mux_ar: got %h rw=%b expected 0200 0", addr, rw); end
    mm = 1'b0; mw = 1'b1;
    #1;
    n_checks++; if (addr !== 16'hC001 || rw !== 1'b1) begin n_fail++; $display("FAIL mux_pc: got %h rw=%b expected C001 1", addr, rw); end
    tick(1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      #1;
      n_checks++; if (addr !== (mm ? m_ar : m_pc) || rw !== mw) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h rw=%b expected %h %b", i, addr, rw, mm ? m_ar : m_pc, mw); end
      tick(1'b1);
      n_checks++; if (pc !== m_pc || ar !== m_ar || ir !== m_ir || page_cross !== m_pcx || ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got pc=%h ar=%h ir=%h pcx=%b rdy=%b expected %h %h %h %b 1", i, pc, ar, ir, page_cross, ready, m_pc, m_ar, m_ir, m_pcx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_reset_mid();
    test_rel();
    test_wrap();
    test_abs_ir();
    test_mux();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
